// File: rtl/game_flow_sequencer.sv
// Game state sequencer: start screen, N levels with life counter, timed clear/death banners, win and game-over screens.
// Optional pause support is compiled in with `define GAME_FLOW_PAUSE_EN.
module game_flow_sequencer #(
    parameter int NUM_LEVELS    = 3,
    parameter int LIVES         = 3,
    parameter int BANNER_CYCLES = 25000000,
    parameter int SEL_W         = 4
) (
    input  logic             vga_clock,
    input  logic             reset,
    input  logic             start_button,
`ifdef GAME_FLOW_PAUSE_EN
    input  logic             pause_button,
`endif
    input  logic             level_win,
    input  logic             level_lose,
    output logic [SEL_W-1:0] screen_sel,
    output logic             level_reset,
    output logic             level_enable,
    output logic             banner_active,
    output logic [3:0]       lives_left
);

    localparam int CNT_W = $clog2(BANNER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TERM  = CNT_W'(BANNER_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_LEVELS);
    localparam logic [SEL_W-1:0] SEL_WIN   = SEL_W'(NUM_LEVELS + 1);
    localparam logic [SEL_W-1:0] SEL_OVER  = SEL_W'(NUM_LEVELS + 2);
    localparam logic [3:0]       LIVES_INI = 4'(LIVES);

    typedef enum logic [2:0] {
        START,
        LOAD,
        PLAY,
        CLEAR,
        DEATH,
        WIN,
        GAME_OVER
`ifdef GAME_FLOW_PAUSE_EN
        , PAUSED
`endif
    } state_t;

    state_t           state;
    logic [SEL_W-1:0] level;
    logic [CNT_W-1:0] banner_cnt;
    logic             start_p0;
    logic             start_p1;
    logic             start_press;

    // Buttons idle high; a press is a high-to-low edge seen across the two sync stages
    assign start_press = start_p1 & ~start_p0;

`ifdef GAME_FLOW_PAUSE_EN
    logic pause_p0;
    logic pause_p1;
    logic pause_press;

    assign pause_press = pause_p1 & ~pause_p0;

    always_ff @(posedge vga_clock) begin
        if (reset) begin
            pause_p0 <= 1'b1;
            pause_p1 <= 1'b1;
        end else begin
            pause_p0 <= pause_button;
            pause_p1 <= pause_p0;
        end
    end
`endif

    always_ff @(posedge vga_clock) begin
        if (reset) begin
            state         <= START;
            screen_sel    <= '0;
            level_reset   <= 1'b0;
            level_enable  <= 1'b0;
            banner_active <= 1'b0;
            lives_left    <= LIVES_INI;
            level         <= SEL_W'(1);
            banner_cnt    <= '0;
            start_p0      <= 1'b1;
            start_p1      <= 1'b1;
        end else begin
            start_p0    <= start_button;
            start_p1    <= start_p0;
            level_reset <= 1'b0;

            case (state)
                START: begin
                    if (start_press) begin
                        state       <= LOAD;
                        level       <= SEL_W'(1);
                        lives_left  <= LIVES_INI;
                        screen_sel  <= SEL_W'(1);
                        level_reset <= 1'b1;
                    end
                end

                LOAD: begin
                    state        <= PLAY;
                    level_enable <= 1'b1;
                end

                PLAY: begin
`ifdef GAME_FLOW_PAUSE_EN
                    if (pause_press) begin
                        state        <= PAUSED;
                        level_enable <= 1'b0;
                    end else
`endif
                    if (level_win) begin
                        level_enable <= 1'b0;
                        banner_cnt   <= '0;
                        if (level == SEL_LAST) begin
                            state      <= WIN;
                            screen_sel <= SEL_WIN;
                        end else begin
                            state         <= CLEAR;
                            banner_active <= 1'b1;
                        end
                    end else if (level_lose) begin
                        level_enable  <= 1'b0;
                        banner_cnt    <= '0;
                        banner_active <= 1'b1;
                        state         <= DEATH;
                        if (lives_left != 4'd0)
                            lives_left <= lives_left - 4'd1;
                    end
                end

                CLEAR: begin
                    if (banner_cnt == CNT_TERM) begin
                        banner_cnt    <= '0;
                        banner_active <= 1'b0;
                        level         <= level + SEL_W'(1);
                        screen_sel    <= level + SEL_W'(1);
                        level_reset   <= 1'b1;
                        state         <= LOAD;
                    end else begin
                        banner_cnt <= banner_cnt + CNT_W'(1);
                    end
                end

                DEATH: begin
                    if (banner_cnt == CNT_TERM) begin
                        banner_cnt    <= '0;
                        banner_active <= 1'b0;
                        if (lives_left == 4'd0) begin
                            state      <= GAME_OVER;
                            screen_sel <= SEL_OVER;
                        end else begin
                            state       <= LOAD;
                            level_reset <= 1'b1;
                        end
                    end else begin
                        banner_cnt <= banner_cnt + CNT_W'(1);
                    end
                end

                WIN, GAME_OVER: begin
                    if (start_press) begin
                        state      <= START;
                        screen_sel <= '0;
                    end
                end

`ifdef GAME_FLOW_PAUSE_EN
                PAUSED: begin
                    if (start_press) begin
                        state      <= START;
                        screen_sel <= '0;
                    end else if (pause_press) begin
                        state        <= PLAY;
                        level_enable <= 1'b1;
                    end
                end
`endif

                default: begin
                    state         <= START;
                    screen_sel    <= '0;
                    level_enable  <= 1'b0;
                    banner_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/game_flow_sequencer.md
Name: game_flow_sequencer

Overview:
- Parametrised top-level game state sequencer that replaces the fixed three-level START/LEVELn/WIN/GAME_OVER controller.
- Sequences any number of levels and tracks a life counter, with timed banner intervals between levels and after deaths.
- Drives a screen-select index and per-level reset/enable strobes to the screen/level multiplexer.
- Sits between board inputs (start_button) and the level/screen drawer instances in the game-logic top.

Parameters:
- NUM_LEVELS, 3, number of playable levels (1..15).
- LIVES, 3, lives at game start (1..15).
- BANNER_CYCLES, 25000000, vga_clock cycles spent in each banner interval (level-clear or death); must be >=1.
- SEL_W, 4, width of screen_sel; must hold NUM_LEVELS+2.

Ports:
- vga_clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start_button  input  1  active-low push button (0 = pressed).
- level_win  input  1  win flag from the active level.
- level_lose  input  1  lose flag from the active level.
- screen_sel  output  SEL_W  0 = start screen, 1..NUM_LEVELS = level k, NUM_LEVELS+1 = win screen, NUM_LEVELS+2 = game-over screen.
- level_reset  output  1  one-cycle pulse that re-initialises the selected level.
- level_enable  output  1  high only while the level is in play; gates the level's inputs.
- banner_active  output  1  high during banner intervals.
- lives_left  output  4  remaining lives.
- pause_button  input  1  active-low; present only with GAME_FLOW_PAUSE_EN.

Behaviour:
- All state is updated on posedge vga_clock. reset is sampled synchronously and has priority over every other event.
- Reset values: state=START, screen_sel=0, level_reset=0, level_enable=0, banner_active=0, lives_left=LIVES, level index=1, banner counter=0.
- start_button is registered once. A "press" is a registered 1->0 transition, so holding the button never re-triggers.
- States and transitions:
  - START: screen_sel=0. On a press, go to LOAD with level=1 and lives=LIVES.
  - LOAD: lasts exactly 1 cycle. level_reset=1 and screen_sel=level. Then go to PLAY.
  - PLAY: level_enable=1 and screen_sel=level.
    - level_win (has priority over a simultaneous level_lose): if level==NUM_LEVELS go to WIN; otherwise go to CLEAR.
    - level_lose alone: lives decrements by 1 and the state goes to DEATH.
    - Flags are only sampled in PLAY; they are ignored in every other state.
  - CLEAR: banner_active=1 and screen_sel=level. The counter runs 0..BANNER_CYCLES-1. On the terminal count, level increments by 1, the counter clears, and the state goes to LOAD.
  - DEATH: banner_active=1, same counter behaviour. On the terminal count: if lives==0 go to GAME_OVER; otherwise go to LOAD with the same level.
  - WIN: screen_sel=NUM_LEVELS+1. A press returns to START.
  - GAME_OVER: screen_sel=NUM_LEVELS+2. A press returns to START.
- Latency: the level flag is sampled in PLAY and the new state is visible on the next cycle. A start press reaches LOAD 2 cycles after the button falls (1 sync register + 1 transition).
- The counter width is $clog2(BANNER_CYCLES+1). The counter is cleared on entry to CLEAR and DEATH.
- lives_left never underflows: a decrement from 1 gives 0, after which GAME_OVER is the only exit from DEATH.
- Reset asserted in any state, including mid-banner: the next cycle shows the reset values, and no level_reset pulse is issued.
- level_enable and level_reset are never high in the same cycle.

Optional Feature:
- GAME_FLOW_PAUSE_EN
- Defined:
  - Adds the pause_button port and a PAUSED state.
  - A pause_button press (registered 1->0) in PLAY goes to PAUSED. In PAUSED: level_enable=0, screen_sel=level, banner_active=0.
  - Another press returns to PLAY. Flags are ignored while PAUSED.
  - A start press while PAUSED goes to START (abandons the game).
- Undefined: the port and state are absent, and PLAY exits only on level_win or level_lose.

Test Plan:
- Parameters NUM_LEVELS=2, LIVES=2, BANNER_CYCLES=4. Reset, then press start -> LOAD pulse (level_reset=1 for 1 cycle), then PLAY with screen_sel=1, lives_left=2.
- In PLAY level 1, pulse level_win -> banner_active high for exactly 4 cycles, then LOAD, then PLAY with screen_sel=2. Pulse level_win again -> screen_sel=3 (WIN) with no banner.
- Level 1, pulse level_lose twice (each after its DEATH banner) -> lives_left 2->1->0, retry stays on screen_sel=1, then screen_sel=4 (GAME_OVER). A start press then gives screen_sel=0.
- Assert level_win and level_lose together in PLAY -> treated as win: lives_left unchanged and the state enters CLEAR.
- Hold start_button low for 10 cycles in WIN -> exactly one return to START; no LOAD until release and re-press.
- Assert reset on banner cycle 2 of DEATH -> next cycle screen_sel=0, lives_left=2, banner_active=0, level_reset=0.
- (GAME_FLOW_PAUSE_EN) Press pause in PLAY -> level_enable=0 and level_win ignored. Press again -> level_enable=1 and the same level resumes.
